// File: rtl/send_pkg.sv
// Shared types and helpers for the multi-lane send stage.
package send_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } send_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/send_channel.sv
// One send lane: sticky arm flag, rise detect, direct/pulse FSM and output register.
module send_channel
  import send_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic data_top_in,
  input  logic en_in,
  input  logic dis,
  input  logic mode,
  output logic data_top_out,
  output logic armed,
  output logic busy,
  output logic launch
);

  localparam int unsigned CMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] PL_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HO_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  send_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          prev, arm_next, rise, out_n, idle_eval;

  always_comb begin
    arm_next = armed;
    if (en_in && dis)              arm_next = 1'b0;
    else if (en_in && data_top_in) arm_next = 1'b1;
  end

  assign rise = data_top_in & ~prev;
  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    out_n     = 1'b0;
    launch    = 1'b0;
    idle_eval = 1'b0;
    case (state)
      IDLE: idle_eval = 1'b1;
      PULSE: begin
        if (!arm_next) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          if (HOLDOFF == 0) begin
            idle_eval = 1'b1;
          end else begin
            state_n = HOLD;
            cnt_n   = HO_LOAD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
          out_n = 1'b1;
        end
      end
      HOLD: begin
        if (!arm_next)        state_n = IDLE;
        else if (cnt == '0)   idle_eval = 1'b1;
        else                  cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // The final busy cycle already behaves as IDLE, so a retrigger sampled on
    // that edge launches back-to-back with exactly HOLDOFF dead cycles.
    if (idle_eval) begin
      state_n = IDLE;
      if (mode == MODE_PULSE) begin
        if (rise && arm_next) begin
          state_n = PULSE;
          cnt_n   = PL_LOAD;
          out_n   = 1'b1;
          launch  = 1'b1;
        end
      end else begin
        out_n = data_top_in & arm_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= 1'b0;
      armed        <= 1'b0;
      data_top_out <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev         <= data_top_in;
      armed        <= arm_next;
      data_top_out <= out_n;
    end
  end

endmodule

// File: rtl/send_n.sv
// Multi-lane send stage: per-lane send_channel instances, bottom pass-through
// and a saturating tally of launched pulses.
module send_n
  import send_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned HOLDOFF   = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] data_top_in,
  input  logic [CHANNELS-1:0] data_bot_in,
  input  logic [CHANNELS-1:0] en_in,
  input  logic [CHANNELS-1:0] dis,
  input  logic                mode,
  input  logic                count_clr,
  output logic [CHANNELS-1:0] data_top_out,
  output logic [CHANNELS-1:0] data_bot_out,
  output logic [CHANNELS-1:0] armed,
  output logic [CHANNELS-1:0] busy,
  output logic [CNT_W-1:0]    sent_count
);

  localparam int unsigned SW = CNT_W + 7;

  logic [CHANNELS-1:0] launch;
  logic [SW-1:0]       sum;
  logic [CNT_W-1:0]    count_n;

  assign data_bot_out = data_bot_in;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    send_channel #(
      .PULSE_LEN(PULSE_LEN),
      .HOLDOFF  (HOLDOFF)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .data_top_in (data_top_in[g]),
      .en_in       (en_in[g]),
      .dis         (dis[g]),
      .mode        (mode),
      .data_top_out(data_top_out[g]),
      .armed       (armed[g]),
      .busy        (busy[g]),
      .launch      (launch[g])
    );
  end

  always_comb begin
    sum     = SW'(sent_count) + SW'(popcount(64'(launch)));
    count_n = (sum[SW-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         sent_count <= '0;
    else if (count_clr) sent_count <= '0;
    else                sent_count <= count_n;
  end

endmodule

// File: doc/send_n.md
# send_n

Parametrised multi-channel successor to the single-channel send stage. Each of CHANNELS lanes carries a top (controlled) line and a bottom (pass-through) line. Each lane has a registered, sticky arm flag and a per-lane FSM. The FSM either forwards the top line directly or converts each rising edge into a fixed-length pulse with hold-off. A shared saturating counter tallies launched pulses. The block sits between the lane data sources and the link drivers.

## Interface
Parameters:
- CHANNELS, 4, number of lanes (≥1)
- PULSE_LEN, 4, cycles data_top_out stays high per launched pulse (≥1)
- HOLDOFF, 2, dead cycles after a pulse during which edges are ignored (≥0)
- CNT_W, 8, width of sent_count

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data_top_in  in  CHANNELS  per-lane top data
- data_bot_in  in  CHANNELS  per-lane bottom data
- en_in  in  CHANNELS  per-lane arm/disarm strobe qualifier
- dis  in  CHANNELS  per-lane disarm request (valid with en_in)
- mode  in  1  0 = direct forward, 1 = pulse mode
- count_clr  in  1  synchronous clear of sent_count
- data_top_out  out  CHANNELS  per-lane controlled top output (registered)
- data_bot_out  out  CHANNELS  equals data_bot_in (combinational)
- armed  out  CHANNELS  per-lane arm flag
- busy  out  CHANNELS  lane in PULSE or HOLD
- sent_count  out  CNT_W  saturating count of pulses launched

## Operation
- Arm flag per lane, registered, no latches. If en_in & dis, next = 0. Else if en_in & !dis & data_top_in, next = 1. Else hold. arm_next is the combinational next value.
- Edge detect per lane. prev register samples data_top_in each cycle. rise = data_top_in & !prev.
- Direct mode (FSM in IDLE, mode=0): data_top_out <= data_top_in & arm_next.
- Pulse-mode FSM per lane: IDLE, PULSE, HOLD.
  - IDLE -> PULSE when mode=1 & rise & arm_next. Load cnt = PULSE_LEN-1.
  - PULSE: output 1. Decrement cnt. At cnt=0, go to HOLD (cnt = HOLDOFF-1), or to IDLE if HOLDOFF=0.
  - HOLD: output 0. Edges are ignored. At cnt=0, go to IDLE.
  - Disarm (arm_next=0) in PULSE or HOLD aborts to IDLE next cycle with output 0.
  - mode is sampled only in IDLE. A mode change mid-pulse does not truncate the pulse.
- The arming edge itself fires, because arm_next qualifies the trigger.
- sent_count:
  - Each cycle, add the popcount of lanes taking IDLE->PULSE, saturating at 2^CNT_W-1.
  - count_clr has priority: the count goes to 0 and launches in that cycle are discarded.
  - Direct mode never counts.

## Timing
- Reset values: data_top_out=0, armed=0, busy=0, sent_count=0, prev=0, FSM=IDLE.
  - Because prev resets to 0, data_top_in already high on the first active edge counts as a rise.
- Direct mode: 1-cycle latency from data_top_in to data_top_out.
- Pulse mode:
  - A rise sampled at edge k drives data_top_out high after edge k, for exactly PULSE_LEN cycles.
  - busy is high for PULSE_LEN+HOLDOFF cycles.
  - The earliest retrigger is sampled at edge k+PULSE_LEN+HOLDOFF.
- armed and sent_count update on the same edge as the triggering sample.
- data_bot_out has zero latency and is unaffected by reset.
- Lanes are fully independent. Simultaneous launches on all lanes add CHANNELS in one cycle.

## Structure
- Package send_pkg:
  - state enum send_state_t {IDLE, PULSE, HOLD}
  - MODE_DIRECT / MODE_PULSE constants
  - popcount function
- Sub-module send_channel:
  - contains the arm flag, edge detect, FSM, counter and output register for one lane
  - instantiated CHANNELS times via generate
- The top level holds the bottom pass-through and the sent_count accumulator.

## Test plan
- Reset with data_top_in=4'b0001, mode=1, en_in=1, dis=0 -> after the first edge armed[0]=1, data_top_out[0] high 4 cycles, then low ≥2 cycles; sent_count=1.
- Pulse retrigger: lane 1 armed, input held high then re-edged 3 cycles after launch -> ignored. Edge at launch+6 -> second pulse; sent_count=2.
- Disarm mid-pulse: en_in[2]=dis[2]=1 on the 2nd pulse cycle -> data_top_out[2]=0 next cycle, busy[2]=0, armed[2]=0.
- Direct mode, lane 3 armed, data_top_in[3] toggled 1010 -> data_top_out[3] shows 1010 delayed by one cycle; sent_count unchanged.
- CNT_W=3, all 4 lanes launch twice -> sent_count saturates at 7. count_clr coincident with a launch -> 0.
- Assert reset low mid-PULSE -> all outputs 0 immediately (asynchronous). Release -> IDLE, armed=0. data_bot_out tracks data_bot_in throughout.
